matrix_row_mac: RTL and testbench

- Downstream consumer of the matrix FIFO in the matrix-vector multiply datapath.
- Holds an N-element vector in a local register bank and waits for the FIFO's ready flag (one full N×N matrix buffered).
- Pops the matrix row by row and multiply-accumulates each row against the vector.
- Emits N dot-product results through a valid/ack handshake towards the result/UART-TX stage.

---
 rtl/global_pkg.sv | 7 +
 rtl/mac_pkg.sv | 19 +
 rtl/mac_unit.sv | 29 ++
 rtl/matrix_row_mac.sv | 132 +++++++++++++
 tb/tb_matrix_row_mac.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/global_pkg.sv
// Datapath-wide element types shared by the FIFO, the MAC stage and the result path.
package global_pkg;
    localparam int DATA_W = 8;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [3:0]        nibble_t;
endpackage

// File: rtl/mac_pkg.sv
// Types and constants for the matrix-row multiply-accumulate stage.
package mac_pkg;
    import global_pkg::*;

    localparam int MAX_N = 8;
    localparam int ACC_W = 2 * DATA_W + 3;

    typedef logic [ACC_W-1:0] acc_t;
    typedef logic [2:0]       idx_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        POP,
        DRAIN,
        EMIT,
        DONE
    } state_t;
endpackage

// File: rtl/mac_unit.sv
// Registered unsigned multiply-accumulate; clr restarts the sum with the current product.
module mac_unit
    import global_pkg::*;
    import mac_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  clr,
    input  logic  en,
    input  data_t a,
    input  data_t b,
    output acc_t  acc
);

    logic [2*DATA_W-1:0] prod;
    acc_t                prod_ext;

    assign prod     = a * b;
    assign prod_ext = acc_t'(prod);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (en) begin
            acc <= clr ? prod_ext : acc + prod_ext;
        end
    end

endmodule

// File: rtl/matrix_row_mac.sv
// Pops a buffered NxN matrix row by row and emits each row's dot product with the local vector.
//   state    | meaning
//   IDLE     | vector writable, waiting for start
//   WAIT_RDY | waiting for the FIFO to hold a full matrix
//   POP      | popping the current row (stalls while the FIFO is empty)
//   DRAIN    | last data beat of the row lands in the accumulator
//   EMIT     | result presented, held until acknowledged
//   DONE     | one-cycle done pulse
module matrix_row_mac
    import global_pkg::*;
    import mac_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    vec_wr,
    input  idx_t    vec_idx,
    input  data_t   vec_data,
    input  nibble_t N,
    input  logic    start,
    input  logic    fifo_ready,
    input  logic    fifo_empty,
    input  data_t   fifo_data,
    output logic    fifo_pop,
    output acc_t    result,
    output logic    result_valid,
    input  logic    result_ack,
    output idx_t    row_idx,
    output logic    busy,
    output logic    done,
    output logic    err
);

    state_t  state, state_nxt;
    nibble_t n_reg;
    nibble_t col;
    idx_t    row;
    idx_t    col_d;
    logic    pop_d;
    logic    first_d;
    data_t   vec [MAX_N];
    acc_t    acc;
    logic    n_ok;
    logic    last_row;

    assign n_ok     = (N != 4'd0) && (N <= 4'(MAX_N));
    assign last_row = ({1'b0, row} == n_reg - 4'd1);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        case (state)
            IDLE:     if (start && n_ok) state_nxt = WAIT_RDY;
            WAIT_RDY: if (fifo_ready) state_nxt = POP;
            POP: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (col == n_reg - 4'd1) state_nxt = DRAIN;
                end
            end
            DRAIN:    state_nxt = EMIT;
            EMIT:     if (result_valid && result_ack) state_nxt = last_row ? DONE : POP;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            n_reg        <= '0;
            col          <= '0;
            row          <= '0;
            col_d        <= '0;
            pop_d        <= 1'b0;
            first_d      <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            row_idx      <= '0;
            err          <= 1'b0;
            for (int i = 0; i < MAX_N; i++) vec[i] <= '0;
        end else begin
            state   <= state_nxt;
            err     <= 1'b0;
            // Pop-side context travels one cycle to meet the returning FIFO data.
            pop_d   <= fifo_pop;
            first_d <= fifo_pop && (col == 4'd0);
            col_d   <= col[2:0];
            case (state)
                IDLE: begin
                    if (vec_wr) vec[vec_idx] <= vec_data;
                    if (start) begin
                        if (n_ok) begin
                            n_reg <= N;
                            row   <= '0;
                            col   <= '0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                POP: begin
                    if (fifo_pop) col <= col + 4'd1;
                end
                EMIT: begin
                    if (!result_valid) begin
                        result       <= acc;
                        row_idx      <= row;
                        result_valid <= 1'b1;
                    end else if (result_ack) begin
                        result_valid <= 1'b0;
                        col          <= '0;
                        if (!last_row) row <= row + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    mac_unit u_mac (
        .clk (clk),
        .rst (rst),
        .clr (first_d),
        .en  (pop_d),
        .a   (fifo_data),
        .b   (vec[col_d]),
        .acc (acc)
    );

endmodule

// File: tb/tb_matrix_row_mac.sv
// Scoreboard bench for matrix_row_mac with a behavioural matrix FIFO and an acknowledging consumer.
module tb_matrix_row_mac;
    import global_pkg::*;
    import mac_pkg::*;

    logic    clk;
    logic    rst;
    logic    vec_wr;
    idx_t    vec_idx;
    data_t   vec_data;
    nibble_t N;
    logic    start;
    logic    fifo_ready;
    logic    fifo_empty;
    data_t   fifo_data;
    logic    fifo_pop;
    acc_t    result;
    logic    result_valid;
    logic    result_ack;
    idx_t    row_idx;
    logic    busy;
    logic    done;
    logic    err;

    typedef struct {
        int row;
        int val;
    } exp_t;

    exp_t  exp_q[$];
    data_t fifo_q[$];
    logic  fe_q;
    logic  stall;
    int    cur_n;
    int    checks;
    int    errors;
    int    done_cnt;
    int    err_cnt;
    int    results_seen;
    int    bp_req;
    int    bp_used;
    int    bp_left;
    acc_t  snap_res;
    idx_t  snap_row;

    assign fifo_empty = fe_q | stall;

    matrix_row_mac dut (
        .clk          (clk),
        .rst          (rst),
        .vec_wr       (vec_wr),
        .vec_idx      (vec_idx),
        .vec_data     (vec_data),
        .N            (N),
        .start        (start),
        .fifo_ready   (fifo_ready),
        .fifo_empty   (fifo_empty),
        .fifo_data    (fifo_data),
        .fifo_pop     (fifo_pop),
        .result       (result),
        .result_valid (result_valid),
        .result_ack   (result_ack),
        .row_idx      (row_idx),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic wvec(input int idx, input int val);
        @(negedge clk);
        vec_wr   = 1'b1;
        vec_idx  = idx[2:0];
        vec_data = val[7:0];
        @(negedge clk);
        vec_wr   = 1'b0;
    endtask

    task automatic push(input int val);
        fifo_q.push_back(val[7:0]);
    endtask

    task automatic expect_res(input int row, input int val);
        exp_t e;
        e.row = row;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic go(input int n);
        cur_n = n;
        @(negedge clk);
        N     = n[3:0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_run(input int d0, input string name);
        for (int i = 0; i < 2000 && done_cnt <= d0; i++) @(negedge clk);
        chk(done_cnt == d0 + 1, {name, "_done_count"}, done_cnt, d0 + 1);
        repeat (2) @(negedge clk);
        chk(exp_q.size() == 0, {name, "_results_missing"}, exp_q.size(), 0);
        chk(busy == 1'b0, {name, "_busy_after"}, busy, 0);
        cur_n = 0;
    endtask

    task automatic bad_start(input int n);
        int e0;
        e0 = err_cnt;
        go(n);
        repeat (3) @(negedge clk);
        chk(err_cnt == e0 + 1, "err_pulse", err_cnt, e0 + 1);
        chk(busy == 1'b0, "busy_bad_start", busy, 0);
    endtask

    initial begin
        int d0;
        int r0;
        bit seen;
        rst = 1'b0; vec_wr = 1'b0; vec_idx = '0; vec_data = '0; N = '0; start = 1'b0;
        fifo_ready = 1'b0; fifo_data = '0; result_ack = 1'b1; fe_q = 1'b1; stall = 1'b0;
        cur_n = 0; checks = 0; errors = 0; done_cnt = 0; err_cnt = 0; results_seen = 0;
        bp_req = 0; bp_used = 0; bp_left = 0; snap_res = '0; snap_row = '0;

        fork
            // matrix FIFO: read data appears the cycle after a pop; cleared by the shared reset
            forever begin
                @(posedge clk or negedge rst);
                if (!rst) begin
                    fifo_q.delete();
                    fifo_data <= '0;
                end else if (fifo_pop && fifo_q.size() > 0) begin
                    fifo_data <= fifo_q.pop_front();
                end
            end
            forever begin
                @(negedge clk);
                fe_q       = (fifo_q.size() == 0);
                fifo_ready = (cur_n != 0) && (fifo_q.size() >= cur_n * cur_n);
            end
            // consumer / monitor
            forever begin
                @(negedge clk);
                if (rst) begin
                    if (done) done_cnt++;
                    if (err) err_cnt++;
                    if (bp_left == 0 && bp_req > bp_used && result_valid && row_idx == 3'd1) begin
                        bp_used++;
                        bp_left  = 10;
                        snap_res = result;
                        snap_row = row_idx;
                    end
                    if (bp_left > 0) begin
                        result_ack = 1'b0;
                        bp_left--;
                        chk(result_valid && result == snap_res && row_idx == snap_row,
                            "bp_hold_stable", result, snap_res);
                        chk(!fifo_pop, "bp_no_pop", fifo_pop, 0);
                    end else begin
                        result_ack = 1'b1;
                    end
                    if (result_valid && result_ack) begin
                        results_seen++;
                        if (exp_q.size() == 0) begin
                            chk(1'b0, "unexpected_result", result, -1);
                        end else begin
                            exp_t e;
                            e = exp_q.pop_front();
                            chk(row_idx == idx_t'(e.row), "row_idx", row_idx, e.row);
                            chk(result == acc_t'(e.val), "result", result, e.val);
                        end
                    end
                end
            end
            begin
                #12;
                chk(result_valid == 1'b0 && fifo_pop == 1'b0, "reset_valid_pop", {result_valid, fifo_pop}, 0);
                chk(busy == 1'b0 && done == 1'b0 && err == 1'b0, "reset_flags", {busy, done, err}, 0);
                chk(result == '0 && row_idx == '0, "reset_result", result, 0);
                @(negedge clk);
                rst = 1'b1;

                // identity
                wvec(0, 3); wvec(1, 5);
                push(1); push(0); push(0); push(1);
                expect_res(0, 3); expect_res(1, 5);
                d0 = done_cnt;
                go(2);
                finish_run(d0, "identity");

                // full size, all 255
                for (int i = 0; i < 8; i++) wvec(i, 255);
                for (int i = 0; i < 64; i++) push(255);
                for (int r = 0; r < 8; r++) expect_res(r, 520200);
                d0 = done_cnt;
                go(8);
                finish_run(d0, "full");

                // backpressure on row 1
                wvec(0, 1); wvec(1, 2); wvec(2, 3);
                for (int i = 1; i <= 9; i++) push(i);
                expect_res(0, 14); expect_res(1, 32); expect_res(2, 50);
                bp_req++;
                d0 = done_cnt;
                go(3);
                finish_run(d0, "backpressure");
                chk(bp_used == bp_req, "bp_happened", bp_used, bp_req);

                // underflow stall mid-row
                wvec(3, 4);
                push(1); push(1); push(1); push(1);
                push(2); push(0); push(1); push(3);
                push(5); push(6); push(7); push(8);
                push(0); push(0); push(0); push(9);
                expect_res(0, 10); expect_res(1, 17); expect_res(2, 70); expect_res(3, 36);
                d0 = done_cnt;
                go(4);
                r0 = 0;
                for (int i = 0; i < 200 && r0 < 2; i++) begin
                    @(negedge clk);
                    if (fifo_pop) r0++;
                end
                chk(r0 == 2, "stall_reach_pop", r0, 2);
                stall = 1'b1;
                repeat (4) begin
                    #1 chk(!fifo_pop, "stall_no_pop", fifo_pop, 0);
                    @(negedge clk);
                end
                stall = 1'b0;
                finish_run(d0, "stall");

                // rejected starts, then a 1x1 run
                bad_start(0);
                bad_start(9);
                wvec(0, 7);
                push(6);
                expect_res(0, 42);
                d0 = done_cnt;
                go(1);
                finish_run(d0, "n1");

                // reset during row 1
                wvec(0, 1); wvec(1, 2); wvec(2, 3); wvec(3, 4);
                for (int i = 0; i < 16; i++) push(1);
                expect_res(0, 10);
                r0 = results_seen;
                go(4);
                for (int i = 0; i < 300 && results_seen <= r0; i++) @(negedge clk);
                chk(results_seen == r0 + 1, "rst_row0_seen", results_seen, r0 + 1);
                seen = 1'b0;
                for (int i = 0; i < 50 && !seen; i++) begin
                    @(negedge clk);
                    seen = fifo_pop;
                end
                chk(seen, "rst_in_pop", seen, 1);
                #2 rst = 1'b0;
                #1;
                chk(busy == 1'b0 && fifo_pop == 1'b0 && result_valid == 1'b0, "rst_async_flags",
                    {busy, fifo_pop, result_valid}, 0);
                chk(result == '0 && row_idx == '0, "rst_async_result", result, 0);
                cur_n = 0;
                @(negedge clk);
                rst = 1'b1;
                chk(exp_q.size() == 0, "rst_sb_empty", exp_q.size(), 0);

                // vector bank was cleared by reset
                push(5);
                expect_res(0, 0);
                d0 = done_cnt;
                go(1);
                finish_run(d0, "post_rst_clear");

                wvec(0, 2); wvec(1, 9);
                push(1); push(1); push(3); push(0);
                expect_res(0, 11); expect_res(1, 6);
                d0 = done_cnt;
                go(2);
                finish_run(d0, "post_rst_run");
                repeat (3) @(negedge clk);
            end
        join_any
        disable fork;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
